// File: rtl/alu_pkg.sv
// Shared ALU types: operation select, condition-code bundle, add/sub sequencer states.
// Latency: none (types and constant helpers only).
// Backpressure: none.
package alu_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } addsub_state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_slice.sv
// WIDTH-bit ripple adder slice; also exposes the carry into its top bit for overflow detection.
// Latency: combinational, one WIDTH-bit ripple.
// Backpressure: none.
module addsub_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    FullAdder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[WIDTH];
  assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract with Y86 condition codes, SLICE bits per clock.
// Latency: WIDTH/SLICE cycles from the accepting edge to the done pulse.
// Backpressure: start is accepted only while idle; starts during busy are dropped, not queued.
module addsub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

  // Operands and result are viewed as arrays of slices so slice k is a plain index.
  addsub_state_t                       state_q, state_d;
  logic          [CW-1:0]              k_q, k_d;
  logic                                carry_q, carry_d;
  alu_op_t                             op_q, op_d;
  logic          [NSLICE-1:0][SLICE-1:0] a_q, a_d;
  logic          [NSLICE-1:0][SLICE-1:0] b_q, b_d;
  logic          [NSLICE-1:0][SLICE-1:0] result_q, result_d;
  cc_t                                 cc_q, cc_d;
  logic                                cf_q, cf_d;
  logic                                done_q, done_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;

  // Subtraction inverts B here; the +1 enters as the initial carry.
  assign sl_a = a_q[k_q];
  assign sl_b = b_q[k_q] ^ {SLICE{op_q == ALU_SUB}};

  addsub_slice #(
    .WIDTH(SLICE)
  ) u_slice (
    .a       (sl_a),
    .b       (sl_b),
    .cin     (carry_q),
    .sum     (sl_sum),
    .cout    (sl_cout),
    .c_msb_in(sl_cmsb)
  );

  // Next state: latch operands when idle, process one slice per RUN cycle, flags on the last slice.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cc_d     = cc_q;
    cf_d     = cf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_t'(op);
          carry_d = op;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[k_q] = sl_sum;
        carry_d       = sl_cout;
        k_d           = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
          done_d  = 1'b1;
          // zf needs the whole word, including the slice being written now.
          cc_d.zf = (result_d == '0);
          cc_d.sf = sl_sum[SLICE-1];
          cc_d.of = sl_cout ^ sl_cmsb;
          cf_d    = sl_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight and clears all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cc_q     <= '0;
      cf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cc_q     <= cc_d;
      cf_q     <= cf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign zf     = cc_q.zf;
  assign sf     = cc_q.sf;
  assign of     = cc_q.of;
  assign cf     = cf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed cases on a 64/8 instance plus randomised runs on four configs.
// Expected responses are queued at issue time and popped by per-instance monitors on done.
module tb_addsub_serial;

  typedef struct packed {
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int fin_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on integers wider than the operands.
  function automatic exp_t model(input int w, input bit o, input logic [63:0] x, input logic [63:0] y);
    logic signed [66:0] ua, ub, sa, sb, t, lim, r;
    exp_t e;
    ua = '0;
    ub = '0;
    for (int i = 0; i < w; i++) begin
      ua[i] = x[i];
      ub[i] = y[i];
    end
    lim  = 67'sd1 <<< w;
    sa   = x[w-1] ? ua - lim : ua;
    sb   = y[w-1] ? ub - lim : ub;
    t    = o ? sa - sb : sa + sb;
    e.of = (t >= (lim >>> 1)) || (t < -(lim >>> 1));
    e.cf = o ? (ua >= ub) : ((ua + ub) >= lim);
    r    = t & (lim - 67'sd1);
    e.res = r[63:0];
    e.zf = (e.res == 64'd0);
    e.sf = e.res[w-1];
    return e;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h7fff_ffff_ffff_ffff;
      4: v = 64'd1 << $urandom_range(0, 63);
      5: v = (64'd1 << $urandom_range(0, 63)) - 64'd1;
      6: v = 64'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- main 64/8 instance ----------------
  logic        rst, start, op;
  logic [63:0] a, b, result;
  logic        busy, done, zf, sf, of, cf;
  exp_t        sb[$];
  exp_t        mon_e;

  addsub_serial #(.WIDTH(64), .SLICE(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .zf    (zf),
    .sf    (sf),
    .of    (of),
    .cf    (cf)
  );

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("main_unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("main_sb", {result, zf, sf, of, cf}, mon_e);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input bit o, input logic [63:0] x, input logic [63:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(64, o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string name, input bit o, input logic [63:0] x, input logic [63:0] y);
    int lat;
    issue(o, x, y);
    check({name, "_busy"}, busy, 1);
    wait_done(lat);
    check({name, "_latency"}, lat, 8);
  endtask

  initial begin : main_seq
    int   lat, n;
    exp_t tmp;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outs", {result, zf, sf, of, cf}, 0);
    rst = 1'b0;
    @(negedge clk);

    run("sub_5_3", 1'b1, 64'd5, 64'd3);
    check("sub_5_3_val", {result, zf, sf, of, cf}, {64'd2, 4'b0001});
    run("sub_min_1", 1'b1, 64'h8000_0000_0000_0000, 64'd1);
    check("sub_min_1_val", {result, zf, sf, of, cf}, {64'h7fff_ffff_ffff_ffff, 4'b0011});
    run("add_max_1", 1'b0, 64'h7fff_ffff_ffff_ffff, 64'd1);
    check("add_max_1_val", {result, zf, sf, of, cf}, {64'h8000_0000_0000_0000, 4'b0110});
    run("add_m1_1", 1'b0, '1, 64'd1);
    check("add_m1_1_val", {result, zf, sf, of, cf}, {64'd0, 4'b1001});

    // Starts and operand changes mid-run must be ignored.
    issue(1'b0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321);
    lat = 0;
    while (!done && lat < 40) begin
      start = (lat == 3 || lat == 5);
      op    = 1'($urandom_range(0, 1));
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("hs_latency", lat, 8);
    check("hs_val", {result, zf, sf, of, cf}, {64'h2222_2222_2222_2211, 4'b0000});
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n++;
    end
    check("hs_no_extra_done", n, 0);

    // Start on the done cycle is accepted.
    run("add_100_23", 1'b0, 64'd100, 64'd23);
    check("add_100_23_val", {result, zf, sf, of, cf}, {64'd123, 4'b0000});
    issue(1'b1, 64'd7, 64'd7);
    wait_done(lat);
    check("b2b_latency", lat, 8);
    check("b2b_val", {result, zf, sf, of, cf}, {64'd0, 4'b1001});

    // Reset four cycles into RUN aborts the operation.
    issue(1'b0, 64'hdead, 64'hbeef);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tmp = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_outs", {done, result, zf, sf, of, cf}, 0);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", n, 0);
    run("post_rst", 1'b1, 64'd1000, 64'd1);
    check("post_rst_val", {result, zf, sf, of, cf}, {64'd999, 4'b0001});

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run("main_rand", 1'($urandom_range(0, 1)), pick(), pick());
    end
    repeat (2) @(negedge clk);
    check("main_sb_empty", sb.size(), 0);

    for (int i = 0; i < 60000 && fin_cnt < 4; i++) @(negedge clk);
    check("all_cfg_finished", fin_cnt, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- randomised configs ----------------
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W  = (g == 2) ? 16 : (g == 3) ? 32 : 64;
    localparam int S  = (g == 0) ? 8 : (g == 1) ? 64 : (g == 2) ? 1 : 4;
    localparam int NS = W / S;

    logic         g_rst, g_start, g_op, g_busy, g_done, g_zf, g_sf, g_of, g_cf;
    logic [W-1:0] g_a, g_b, g_res;
    exp_t         q[$];
    exp_t         me;

    addsub_serial #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk   (clk),
      .rst   (g_rst),
      .start (g_start),
      .op    (g_op),
      .a     (g_a),
      .b     (g_b),
      .busy  (g_busy),
      .done  (g_done),
      .result(g_res),
      .zf    (g_zf),
      .sf    (g_sf),
      .of    (g_of),
      .cf    (g_cf)
    );

    always @(negedge clk) begin
      if (g_done) begin
        if (q.size() == 0) begin
          check($sformatf("cfg_W%0d_S%0d_unexpected_done", W, S), 1, 0);
        end else begin
          me = q.pop_front();
          check($sformatf("cfg_W%0d_S%0d_sb", W, S), {64'(g_res), g_zf, g_sf, g_of, g_cf}, me);
        end
      end
    end

    initial begin : stim
      logic [63:0] x, y;
      bit          o;
      int          lat;
      g_rst = 1'b1; g_start = 1'b0; g_op = 1'b0; g_a = '0; g_b = '0;
      repeat (2) @(negedge clk);
      g_rst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        x = pick();
        y = pick();
        o = 1'($urandom_range(0, 1));
        g_start = 1'b1;
        g_op    = o;
        g_a     = x[W-1:0];
        g_b     = y[W-1:0];
        q.push_back(model(W, o, x, y));
        @(negedge clk);
        g_start = 1'b0;
        lat = 0;
        while (!g_done && lat < NS + 10) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("cfg_W%0d_S%0d_latency", W, S), lat, NS);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      @(negedge clk);
      check($sformatf("cfg_W%0d_S%0d_sb_empty", W, S), q.size(), 0);
      fin_cnt++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
    $fatal(1);
  end

endmodule
